// File: rtl/tx_pcs_encoder.sv
// 64b/66b transmit encoder: pairs two 32-bit XGMII words into one 8-lane block
// and emits the 10GBASE-R sync header plus payload through a valid/ready output.
module tx_pcs_encoder #(
    parameter int XGMII_DATA_WIDTH = 32,
    parameter int XGMII_DATA_BYTES = 4
) (
    input  logic                          tx_clk,
    input  logic                          tx_rst,
    input  logic [XGMII_DATA_WIDTH-1:0]   in_xgmii_data,
    input  logic [XGMII_DATA_BYTES-1:0]   in_xgmii_ctl,
    output logic                          out_xgmii_pcs_ready,
    output logic [1:0]                    out_pcs_header,
    output logic [2*XGMII_DATA_WIDTH-1:0] out_pcs_data,
    output logic                          out_pcs_valid,
    input  logic                          in_pcs_ready,
    output logic                          out_encode_err
);

    localparam int BLK_LANES = 2 * XGMII_DATA_BYTES;
    localparam int BLK_BITS  = 2 * XGMII_DATA_WIDTH;

    localparam logic [7:0] XGMII_IDLE  = 8'h07;
    localparam logic [7:0] XGMII_START = 8'hFB;
    localparam logic [7:0] XGMII_TERM  = 8'hFD;
    localparam logic [7:0] TYPE_CTRL   = 8'h1E;
    localparam logic [7:0] TYPE_START  = 8'h78;

    // Error block: type byte followed by eight 7-bit error control codes.
    localparam logic [BLK_BITS-1:0] ERR_BLOCK = {{8{7'h1E}}, TYPE_CTRL};

    logic                          phase;
    logic [XGMII_DATA_WIDTH-1:0]   held_data;
    logic [XGMII_DATA_BYTES-1:0]   held_ctl;
    logic [BLK_BITS-1:0]           blk_data;
    logic [BLK_LANES-1:0]          blk_ctl;
    logic [BLK_LANES-1:0]          idle_lane;
    logic                          load;
    logic [1:0]                    enc_header;
    logic [BLK_BITS-1:0]           enc_data;
    logic                          enc_err;

    function automatic logic [7:0] term_type(input int k);
        case (k)
            0:       term_type = 8'h87;
            1:       term_type = 8'h99;
            2:       term_type = 8'hAA;
            3:       term_type = 8'hB4;
            4:       term_type = 8'hCC;
            5:       term_type = 8'hD2;
            6:       term_type = 8'hE1;
            default: term_type = 8'hFF;
        endcase
    endfunction

    assign out_xgmii_pcs_ready = !out_pcs_valid || in_pcs_ready;
    assign load                = out_xgmii_pcs_ready && phase;

    // The block is the held phase-0 word in lanes 0-3 and the live word in lanes 4-7.
    assign blk_data = {in_xgmii_data, held_data};
    assign blk_ctl  = {in_xgmii_ctl, held_ctl};

    for (genvar i = 0; i < BLK_LANES; i++) begin : g_idle
        assign idle_lane[i] = blk_ctl[i] && (blk_data[8*i +: 8] == XGMII_IDLE);
    end

    always_comb begin
        enc_header = 2'b10;
        enc_data   = ERR_BLOCK;
        enc_err    = 1'b1;
        if (blk_ctl == '0) begin
            enc_header = 2'b01;
            enc_data   = blk_data;
            enc_err    = 1'b0;
        end else if (&idle_lane) begin
            enc_data = {{(BLK_BITS-8){1'b0}}, TYPE_CTRL};
            enc_err  = 1'b0;
        end else if (blk_ctl == 8'h01 && blk_data[7:0] == XGMII_START) begin
            enc_data = {blk_data[BLK_BITS-1:8], TYPE_START};
            enc_err  = 1'b0;
        end else begin
            // Lanes before the terminate shift up one byte to make room for the type.
            for (int k = 0; k < BLK_LANES; k++) begin
                if (blk_ctl == 8'(8'hFF << k) &&
                    blk_data[8*k +: 8] == XGMII_TERM &&
                    &(idle_lane | 8'(8'hFF >> (7 - k)))) begin
                    enc_data = ({blk_data[BLK_BITS-9:0], 8'h00} &
                                ((64'd1 << (8*k + 8)) - 64'd1)) |
                               {{(BLK_BITS-8){1'b0}}, term_type(k)};
                    enc_err  = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge tx_clk) begin
        if (tx_rst) begin
            phase          <= 1'b0;
            held_data      <= '0;
            held_ctl       <= '0;
            out_pcs_header <= 2'b00;
            out_pcs_data   <= '0;
            out_pcs_valid  <= 1'b0;
            out_encode_err <= 1'b0;
        end else begin
            if (out_xgmii_pcs_ready) begin
                phase <= ~phase;
                if (!phase) begin
                    held_data <= in_xgmii_data;
                    held_ctl  <= in_xgmii_ctl;
                end
            end
            if (load) begin
                out_pcs_header <= enc_header;
                out_pcs_data   <= enc_data;
                out_pcs_valid  <= 1'b1;
                out_encode_err <= enc_err;
            end else begin
                out_encode_err <= 1'b0;
                if (in_pcs_ready)
                    out_pcs_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tx_pcs_encoder.sv
// Bench for tx_pcs_encoder: directed literal blocks, a stall, mid-block reset and
// randomized blocks, all checked every cycle against a rule-based block model.
module tb_tx_pcs_encoder;

    logic        tx_clk = 1'b0;
    logic        tx_rst;
    logic [31:0] in_xgmii_data;
    logic [3:0]  in_xgmii_ctl;
    logic        out_xgmii_pcs_ready;
    logic [1:0]  out_pcs_header;
    logic [63:0] out_pcs_data;
    logic        out_pcs_valid;
    logic        in_pcs_ready;
    logic        out_encode_err;

    int n_checks = 0;
    int n_pass   = 0;
    bit rand_ready = 1'b0;

    localparam logic [7:0] TERM_TYPES [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4,
                                              8'hCC, 8'hD2, 8'hE1, 8'hFF};

    tx_pcs_encoder #(.XGMII_DATA_WIDTH(32), .XGMII_DATA_BYTES(4)) dut (
        .tx_clk              (tx_clk),
        .tx_rst              (tx_rst),
        .in_xgmii_data       (in_xgmii_data),
        .in_xgmii_ctl        (in_xgmii_ctl),
        .out_xgmii_pcs_ready (out_xgmii_pcs_ready),
        .out_pcs_header      (out_pcs_header),
        .out_pcs_data        (out_pcs_data),
        .out_pcs_valid       (out_pcs_valid),
        .in_pcs_ready        (in_pcs_ready),
        .out_encode_err      (out_encode_err)
    );

    always #5 tx_clk = ~tx_clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp)
            n_pass++;
        else
            $display("[TB] FAIL %s: actual %0h, required %0h", name, act, exp);
    endtask

    // Block encoding written directly from the lane classification rules.
    function automatic void model_encode(input logic [63:0] d, input logic [7:0] c,
                                         output logic [1:0] h, output logic [63:0] o,
                                         output logic e);
        logic [7:0] ln [8];
        bit found, all_idle, rest_idle;
        for (int i = 0; i < 8; i++) ln[i] = d[8*i +: 8];
        h = 2'b10; o = '0; e = 1'b0; found = 0;
        all_idle = (c == 8'hFF);
        for (int i = 0; i < 8; i++) if (ln[i] != 8'h07) all_idle = 0;
        if (c == 8'h00) begin
            h = 2'b01; o = d; found = 1;
        end else if (all_idle) begin
            o = 64'h1E; found = 1;
        end else if (c == 8'h01 && ln[0] == 8'hFB) begin
            o = {d[63:8], 8'h78}; found = 1;
        end else begin
            for (int k = 0; k < 8; k++) begin
                rest_idle = 1;
                for (int j = k + 1; j < 8; j++) if (ln[j] != 8'h07) rest_idle = 0;
                if (!found && c == 8'(8'hFF << k) && ln[k] == 8'hFD && rest_idle) begin
                    o[7:0] = TERM_TYPES[k];
                    for (int j = 0; j < k; j++) o[8*j + 8 +: 8] = ln[j];
                    found = 1;
                end
            end
        end
        if (!found) begin
            o = 64'h1E;
            for (int i = 0; i < 8; i++) o[8 + 7*i +: 7] = 7'h1E;
            e = 1'b1;
        end
    endfunction

    // Cycle model: handshake rules plus the pending-block state, compared every cycle.
    bit          m_known = 0, m_valid, m_phase, m_err, m_rst;
    logic [1:0]  m_hdr;
    logic [63:0] m_data;
    logic [31:0] m_lo_d;
    logic [3:0]  m_lo_c;

    always @(negedge tx_clk) begin
        bit acc;
        if (m_known) begin
            checkOutput("ready", 64'(out_xgmii_pcs_ready), 64'(!m_valid || in_pcs_ready));
            checkOutput("valid", 64'(out_pcs_valid), 64'(m_valid));
            checkOutput("encode_err", 64'(out_encode_err), 64'(m_err));
            if (m_valid || m_rst) begin
                checkOutput("header", 64'(out_pcs_header), 64'(m_hdr));
                checkOutput("data", out_pcs_data, m_data);
            end
        end
        if (tx_rst) begin
            m_known = 1; m_valid = 0; m_phase = 0; m_err = 0; m_rst = 1;
            m_hdr = 2'b00; m_data = '0;
        end else if (m_known) begin
            m_rst = 0;
            acc = !m_valid || in_pcs_ready;
            if (acc && m_phase) begin
                model_encode({in_xgmii_data, m_lo_d}, {in_xgmii_ctl, m_lo_c}, m_hdr, m_data, m_err);
                m_valid = 1;
            end else begin
                m_err = 0;
                if (in_pcs_ready) m_valid = 0;
            end
            if (acc) begin
                if (!m_phase) begin m_lo_d = in_xgmii_data; m_lo_c = in_xgmii_ctl; end
                m_phase = !m_phase;
            end
        end
    end

    always begin
        @(posedge tx_clk);
        #2;
        if (rand_ready) in_pcs_ready = ($urandom_range(0, 3) != 0);
    end

    task automatic applyStimulus(input logic [31:0] d, input logic [3:0] c);
        bit done = 0;
        in_xgmii_data = d;
        in_xgmii_ctl  = c;
        for (int i = 0; i < 64 && !done; i++) begin
            @(negedge tx_clk);
            done = out_xgmii_pcs_ready;
            @(posedge tx_clk);
            #1;
        end
        if (!done) begin
            n_checks++;
            $display("[TB] FAIL accept_timeout: word %h not accepted within 64 cycles", d);
        end
    endtask

    task automatic sendBlock(input logic [63:0] d, input logic [7:0] c);
        applyStimulus(d[31:0], c[3:0]);
        applyStimulus(d[63:32], c[7:4]);
    endtask

    task automatic expectBlock(input string name, input logic [1:0] h, input logic [63:0] d, input logic e);
        @(negedge tx_clk);
        checkOutput({name, "_valid"}, 64'(out_pcs_valid), 64'd1);
        checkOutput({name, "_hdr"}, 64'(out_pcs_header), 64'(h));
        checkOutput({name, "_data"}, out_pcs_data, d);
        checkOutput({name, "_err"}, 64'(out_encode_err), 64'(e));
    endtask

    task automatic pinModel(input string name, input logic [63:0] d, input logic [7:0] c,
                            input logic [1:0] h, input logic [63:0] o, input logic e);
        logic [1:0] mh; logic [63:0] mo; logic me;
        model_encode(d, c, mh, mo, me);
        checkOutput({name, "_hdr"}, 64'(mh), 64'(h));
        checkOutput({name, "_data"}, mo, o);
        checkOutput({name, "_err"}, 64'(me), 64'(e));
    endtask

    task automatic genRandomBlock(output logic [63:0] d, output logic [7:0] c);
        int k;
        d = {$urandom, $urandom};
        c = 8'h00;
        case ($urandom_range(0, 5))
            0: c = 8'h00;
            1: begin d = {8{8'h07}}; c = 8'hFF; end
            2: begin d[7:0] = 8'hFB; c = 8'h01; end
            3: begin
                k = $urandom_range(0, 7);
                c = 8'(8'hFF << k);
                d[8*k +: 8] = 8'hFD;
                for (int j = k + 1; j < 8; j++) d[8*j +: 8] = 8'h07;
            end
            4: begin d[39:32] = 8'hFB; c = 8'h10; end
            default: begin
                d = {8{8'h07}};
                d[8*$urandom_range(0, 7) +: 8] = 8'($urandom_range(0, 255));
                c = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom);
            end
        endcase
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [63:0] rd;
        logic [7:0]  rc;
        tx_rst        = 1'b1;
        in_pcs_ready  = 1'b1;
        in_xgmii_data = 32'h07070707;
        in_xgmii_ctl  = 4'hF;
        repeat (3) @(posedge tx_clk);
        #1;
        tx_rst = 1'b0;

        pinModel("pin_idle", {8{8'h07}}, 8'hFF, 2'b10, 64'h1E, 1'b0);
        pinModel("pin_term0", 64'h07070707_070707FD, 8'hFF, 2'b10, 64'h87, 1'b0);
        pinModel("pin_term7", 64'hFD776655_44332211, 8'h80, 2'b10, 64'h77665544_332211FF, 1'b0);
        pinModel("pin_data", 64'h01234567_89ABCDEF, 8'h00, 2'b01, 64'h01234567_89ABCDEF, 1'b0);
        pinModel("pin_err", 64'h07070707_070707FE, 8'hFF, 2'b10, 64'h3C78F1E3_C78F1E1E, 1'b1);

        sendBlock({8{8'h07}}, 8'hFF);
        fork expectBlock("idle_pair", 2'b10, 64'h1E, 1'b0); join_none
        sendBlock({32'hD5555555, 32'hD55555FB}, 8'h01);
        fork expectBlock("start", 2'b10, 64'hD5555555_D5555578, 1'b0); join_none
        sendBlock({32'h070707FD, 32'h44332211}, 8'hF0);
        fork expectBlock("term4", 2'b10, 64'h00000044_332211CC, 1'b0); join_none
        sendBlock({32'h07070707, 32'h070707FE}, 8'hFF);
        fork expectBlock("error", 2'b10, 64'h3C78F1E3_C78F1E1E, 1'b1); join_none

        // Stall the output for five cycles with a data block pending.
        sendBlock(64'h01234567_89ABCDEF, 8'h00);
        in_pcs_ready = 1'b0;
        fork
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge tx_clk);
                    checkOutput("stall_ready", 64'(out_xgmii_pcs_ready), 64'd0);
                    checkOutput("stall_data", out_pcs_data, 64'h01234567_89ABCDEF);
                end
            end
            begin
                repeat (5) @(posedge tx_clk);
                #1;
                in_pcs_ready = 1'b1;
            end
        join_none
        sendBlock({8{8'h07}}, 8'hFF);

        // Reset with only a phase-0 word accepted; that word must not leak.
        applyStimulus(32'h11111111, 4'h0);
        tx_rst = 1'b1;
        repeat (2) @(posedge tx_clk);
        #1;
        tx_rst = 1'b0;
        sendBlock({8{8'h07}}, 8'hFF);
        fork expectBlock("post_reset_idle", 2'b10, 64'h1E, 1'b0); join_none

        rand_ready = 1'b1;
        for (int n = 0; n < 300; n++) begin
            genRandomBlock(rd, rc);
            sendBlock(rd, rc);
        end
        rand_ready   = 1'b0;
        in_pcs_ready = 1'b1;
        sendBlock({8{8'h07}}, 8'hFF);
        sendBlock({8{8'h07}}, 8'hFF);
        repeat (4) @(posedge tx_clk);
        #1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
